iigs_slot_bus: RTL and testbench
================================

Name: iigs_slot_bus

Overview:
Parametrised Apple IIe-style peripheral slot decoder and read-return path for the IIgs core. Turns the CPU bus (bank/addr/we plus a bus-cycle enable) into per-slot DEVICE_SELECT, I/O_SELECT and I/O_STROBE pulses. Tracks ownership of the shared $C800–$CFFF expansion-ROM window and returns the selected card's read data. Sits between the core and external slot-card models, replacing ad-hoc slot_ce decoding at top level.

Parameters:
NUM_SLOTS, 7, number of populated slot positions (1..NUM_SLOTS); range 1–7
EXP_ROM_EN, 1, 1 = implement the $C800 expansion-ROM owner latch; 0 = io_strobe never asserted
SW, NUM_SLOTS+1, derived vector width; bit 0 unused and always driven 0

Ports:
CLK_14M  in  1  system clock
reset  in  1  asynchronous active-high reset
bus_en  in  1  one-cycle bus-access strobe (phi2 enable); decode happens only when high
bank  in  8  CPU bank
addr  in  16  CPU address
we  in  1  1 = write access
sltromsel  in  8  SLTROMSEL register; bit n = 1 means slot n is external
inhibit_cxxx  in  1  suppresses all $C100–$CFFF slot decoding
card_present  in  SW  bit n = card in slot n
card_dout  in  8*SW  card read data; slot n on bits [8n+7:8n]
device_select  out  SW  one-cycle pulse, $C080+16n..$C08F+16n
io_select  out  SW  one-cycle pulse, $Cn00–$CnFF
io_strobe  out  SW  one-cycle pulse, $C800–$CFFF to the owning slot
exp_owner  out  3  current expansion-ROM owner; 0 = none
slot_hit  out  1  registered: the last decoded read targeted a present external card
slot_dout  out  8  registered read data
rd_valid  out  1  one-cycle pulse; slot_dout/slot_hit are valid

Behaviour:
- Reset: all outputs 0, exp_owner 0, pipeline empty. Reset during an access abandons it with no late pulses.
- Qualifying bank: 00, 01, E0, E1. Other banks: no strobes, no owner change, rd_valid still pulses with slot_hit=0, slot_dout=0.
- Stage T (bus_en high): decode to a slot n (1..7) and kind:
  - DEV: addr $C080–$C0FF, n = addr[6:4].
  - IOSEL: addr $C100–$C7FF, n = addr[10:8].
  - STRB: addr $C800–$CFFF, n = exp_owner.
- External-slot gating: only when sltromsel[n]=1, n≤NUM_SLOTS and n≠0.
- inhibit_cxxx blocks IOSEL and STRB, not DEV.
- T+1: the matching select bit pulses for exactly one cycle. All other bits stay 0. At most one bit across all three vectors is high.
- Cards drive card_dout during T+1.
- T+2: slot_dout = card_dout lane n when the access was a read and card_present[n]=1, else 0. slot_hit is set to match. rd_valid pulses for every bus_en, including writes (slot_hit=0 for writes). Fixed latency is 2 cycles.
- Owner latch (EXP_ROM_EN=1), updated at T+1:
  - A gated IOSEL to slot n sets exp_owner=n (read or write).
  - Any qualifying access to $CFFF, ungated by inhibit_cxxx? No — it is gated by inhibit_cxxx. It first issues io_strobe to the current owner (if nonzero), then clears exp_owner to 0.
  - STRB with exp_owner=0: no strobe, slot_hit=0.
  - If sltromsel[owner] is cleared while owned, exp_owner is retained but strobes are suppressed until the bit returns.
- bus_en asserted on back-to-back cycles: fully pipelined; each access is processed independently in order. An owner update at T+1 affects a STRB decoded at T+1.
- EXP_ROM_EN=0: exp_owner is held at 0.

Decomposition:
- Shared package iigs_slot_pkg:
  - address constants: C080 base, C100, C800, CFFF.
  - qualifying-bank list.
  - access-kind enum: NONE/DEV/IOSEL/STRB.
- One natural sub-module: iigs_slot_addr_decode. It is purely combinational: (bank, addr, sltromsel, inhibit_cxxx, exp_owner) -> {kind, slot, gated}.
- Pipeline registers, owner latch and data mux live in iigs_slot_bus.

Test Plan:
- sltromsel=8'h40, card_present[6]=1, card_dout lane 6=8'hA5; read bank 00 $C0E3 -> device_select=8'h40 at T+1; slot_dout=A5, slot_hit=1, rd_valid at T+2.
- Read E1:$C600 then 00:$C812 (sltromsel[6]=1) -> io_select[6] pulse, exp_owner=6, then io_strobe[6] pulse. Read $CFFF -> io_strobe[6] pulse, then exp_owner=0. Next $C812 -> no strobe, slot_hit=0.
- inhibit_cxxx=1; read $C600 and $C085 -> no io_select and exp_owner unchanged; device_select[0..] pulses bit 0? No: $C085 -> slot 0, so no strobe. Then $C0B0 -> device_select[3] pulse if sltromsel[3]=1.
- sltromsel[5]=0; read $C500 -> no strobe, slot_hit=0, rd_valid pulses; bank 02:$C600 -> no strobe.
- NUM_SLOTS=4; read $C700 with sltromsel=8'hFF -> no strobe, slot_hit=0.
- Back-to-back bus_en reading $C600 then $C800 -> io_select[6] at T+1, io_strobe[6] at T+2; assert reset mid-stream -> all outputs 0 immediately, exp_owner=0.

Source files
------------

// File: rtl/iigs_slot_pkg.sv
// Shared definitions for the IIgs peripheral slot decoder: address map,
// qualifying banks and the access-kind encoding.
package iigs_slot_pkg;

  localparam logic [15:0] ADDR_C080 = 16'hC080;
  localparam logic [15:0] ADDR_C0FF = 16'hC0FF;
  localparam logic [15:0] ADDR_C100 = 16'hC100;
  localparam logic [15:0] ADDR_C7FF = 16'hC7FF;
  localparam logic [15:0] ADDR_C800 = 16'hC800;
  localparam logic [15:0] ADDR_CFFF = 16'hCFFF;

  // Banks 00/01 and their E0/E1 shadows are the only ones that see the slot I/O space.
  localparam int NUM_QUAL_BANKS = 4;
  localparam logic [8*NUM_QUAL_BANKS-1:0] QUAL_BANKS = {8'hE1, 8'hE0, 8'h01, 8'h00};

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_DEV   = 2'd1,
    KIND_IOSEL = 2'd2,
    KIND_STRB  = 2'd3
  } kind_e;

  function automatic logic bank_qualifies(input logic [7:0] bank);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_QUAL_BANKS; i++) begin
      if (bank == QUAL_BANKS[8*i +: 8]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/iigs_slot_addr_decode.sv
// Combinational slot decoder: classifies a bus address into an access kind,
// the target slot, and whether that slot is an enabled external card.
module iigs_slot_addr_decode
  import iigs_slot_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 7
) (
  input  logic [7:0]  bank,
  input  logic [15:0] addr,
  input  logic [7:0]  sltromsel,
  input  logic        inhibit_cxxx,
  input  logic [2:0]  exp_owner,
  output kind_e       kind,
  output logic [2:0]  slot,
  output logic        gated,
  output logic        owner_clr
);

  always_comb begin
    kind = KIND_NONE;
    slot = 3'd0;
    if (bank_qualifies(bank)) begin
      if (addr >= ADDR_C080 && addr <= ADDR_C0FF) begin
        kind = KIND_DEV;
        slot = addr[6:4];
      end else if (addr >= ADDR_C100 && addr <= ADDR_C7FF) begin
        kind = KIND_IOSEL;
        slot = addr[10:8];
      end else if (addr >= ADDR_C800 && addr <= ADDR_CFFF) begin
        kind = KIND_STRB;
        slot = exp_owner;
      end
    end

    // $CFFF releases the window even when the owner's strobe is suppressed.
    owner_clr = (kind == KIND_STRB) && (addr == ADDR_CFFF) && !inhibit_cxxx;

    gated = (kind != KIND_NONE) && (slot != 3'd0) && (32'(slot) <= NUM_SLOTS) &&
            sltromsel[slot] && ((kind == KIND_DEV) || !inhibit_cxxx);
  end

endmodule

// File: rtl/iigs_slot_bus.sv
// Apple IIe-style slot bus for the IIgs core: per-slot select pulses one cycle
// after a bus access, $C800 window ownership, and a two-cycle read-return path.
module iigs_slot_bus
  import iigs_slot_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 7,
  parameter bit          EXP_ROM_EN = 1'b1,
  parameter int unsigned SW         = NUM_SLOTS + 1
) (
  input  logic            CLK_14M,
  input  logic            reset,
  input  logic            bus_en,
  input  logic [7:0]      bank,
  input  logic [15:0]     addr,
  input  logic            we,
  input  logic [7:0]      sltromsel,
  input  logic            inhibit_cxxx,
  input  logic [SW-1:0]   card_present,
  input  logic [8*SW-1:0] card_dout,
  output logic [SW-1:0]   device_select,
  output logic [SW-1:0]   io_select,
  output logic [SW-1:0]   io_strobe,
  output logic [2:0]      exp_owner,
  output logic            slot_hit,
  output logic [7:0]      slot_dout,
  output logic            rd_valid
);

  kind_e       dec_kind;
  logic [2:0]  dec_slot;
  logic        dec_gated, dec_owner_clr;
  logic [7:0]  slot_oh;

  logic [SW-1:0] dev_sel_d, dev_sel_q, io_sel_d, io_sel_q, io_strb_d, io_strb_q;
  logic [2:0]    exp_owner_d, exp_owner_q;
  logic          vld_p0_d, vld_p0_q, rd_p0_d, rd_p0_q;
  logic [2:0]    slot_p0_d, slot_p0_q;
  logic          vld_p1_d, vld_p1_q, slot_hit_d, slot_hit_q;
  logic [7:0]    slot_dout_d, slot_dout_q, lane_sel;
  logic          present_sel;

  iigs_slot_addr_decode #(.NUM_SLOTS(NUM_SLOTS)) u_decode (
    .bank         (bank),
    .addr         (addr),
    .sltromsel    (sltromsel),
    .inhibit_cxxx (inhibit_cxxx),
    .exp_owner    (exp_owner_q),
    .kind         (dec_kind),
    .slot         (dec_slot),
    .gated        (dec_gated),
    .owner_clr    (dec_owner_clr)
  );

  assign slot_oh = 8'd1 << dec_slot;

  // Stage T -> p0: select pulses, owner latch, read candidate
  always_comb begin
    dev_sel_d   = '0;
    io_sel_d    = '0;
    io_strb_d   = '0;
    exp_owner_d = exp_owner_q;
    vld_p0_d    = bus_en;
    rd_p0_d     = bus_en && dec_gated && !we;
    slot_p0_d   = dec_slot;
    if (bus_en && dec_gated) begin
      unique case (dec_kind)
        KIND_DEV:   dev_sel_d = slot_oh[SW-1:0];
        KIND_IOSEL: io_sel_d  = slot_oh[SW-1:0];
        KIND_STRB:  io_strb_d = slot_oh[SW-1:0];
        default:    ;
      endcase
    end
    if (!EXP_ROM_EN) begin
      exp_owner_d = 3'd0;
    end else if (bus_en) begin
      if (dec_gated && dec_kind == KIND_IOSEL) exp_owner_d = dec_slot;
      else if (dec_owner_clr)                  exp_owner_d = 3'd0;
    end
  end

  // Stage p0 -> p1: capture the addressed card's lane while it drives the bus
  always_comb begin
    lane_sel    = '0;
    present_sel = 1'b0;
    for (int unsigned i = 0; i < SW; i++) begin
      if (32'(slot_p0_q) == i) begin
        lane_sel    = card_dout[8*i +: 8];
        present_sel = card_present[i];
      end
    end
    vld_p1_d    = vld_p0_q;
    slot_hit_d  = slot_hit_q;
    slot_dout_d = slot_dout_q;
    if (vld_p0_q) begin
      slot_hit_d  = rd_p0_q && present_sel;
      slot_dout_d = (rd_p0_q && present_sel) ? lane_sel : 8'h00;
    end
  end

  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      dev_sel_q   <= '0;
      io_sel_q    <= '0;
      io_strb_q   <= '0;
      exp_owner_q <= 3'd0;
      vld_p0_q    <= 1'b0;
      rd_p0_q     <= 1'b0;
      vld_p1_q    <= 1'b0;
      slot_hit_q  <= 1'b0;
      slot_dout_q <= 8'h00;
    end else begin
      dev_sel_q   <= dev_sel_d;
      io_sel_q    <= io_sel_d;
      io_strb_q   <= io_strb_d;
      exp_owner_q <= exp_owner_d;
      vld_p0_q    <= vld_p0_d;
      rd_p0_q     <= rd_p0_d;
      vld_p1_q    <= vld_p1_d;
      slot_hit_q  <= slot_hit_d;
      slot_dout_q <= slot_dout_d;
    end
  end

  always_ff @(posedge CLK_14M) begin
    slot_p0_q <= slot_p0_d;
  end

  assign device_select = dev_sel_q;
  assign io_select     = io_sel_q;
  assign io_strobe     = io_strb_q;
  assign exp_owner     = exp_owner_q;
  assign slot_hit      = slot_hit_q;
  assign slot_dout     = slot_dout_q;
  assign rd_valid      = vld_p1_q;

endmodule

// File: tb/tb_iigs_slot_bus.sv
// Bench for iigs_slot_bus: directed and random bus accesses compared against a
// per-access reference model of the slot address map and $C800 ownership rules.
module tb_iigs_slot_bus;

  typedef struct packed {
    logic       valid;
    logic [7:0] dev;
    logic [7:0] ios;
    logic [7:0] stb;
    logic       hit;
    logic [7:0] dout;
  } rec_t;

  localparam int M_SLOTS = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_en = 1'b0;
  logic [7:0]  bank = 8'h00;
  logic [15:0] addr = 16'h0000;
  logic        we = 1'b0;
  logic [7:0]  sltromsel = 8'h00;
  logic        inhibit_cxxx = 1'b0;
  logic [7:0]  card_present = 8'h00;
  logic [63:0] card_dout = 64'h0;

  logic [7:0]  device_select, io_select, io_strobe, slot_dout;
  logic [2:0]  exp_owner;
  logic        slot_hit, rd_valid;

  logic [4:0]  d2_device_select, d2_io_select, d2_io_strobe;
  logic [7:0]  d2_slot_dout;
  logic [2:0]  d2_exp_owner;
  logic        d2_slot_hit, d2_rd_valid;

  int passed = 0;
  int total  = 0;

  logic [2:0] m_owner = 3'd0;
  rec_t st1 = '0;
  rec_t st2 = '0;

  always #5 clk = ~clk;

  iigs_slot_bus dut (
    .CLK_14M(clk), .reset(reset), .bus_en(bus_en), .bank(bank), .addr(addr), .we(we),
    .sltromsel(sltromsel), .inhibit_cxxx(inhibit_cxxx), .card_present(card_present),
    .card_dout(card_dout), .device_select(device_select), .io_select(io_select),
    .io_strobe(io_strobe), .exp_owner(exp_owner), .slot_hit(slot_hit),
    .slot_dout(slot_dout), .rd_valid(rd_valid)
  );

  iigs_slot_bus #(.NUM_SLOTS(4)) dut4 (
    .CLK_14M(clk), .reset(reset), .bus_en(bus_en), .bank(bank), .addr(addr), .we(we),
    .sltromsel(sltromsel), .inhibit_cxxx(inhibit_cxxx), .card_present(card_present[4:0]),
    .card_dout(card_dout[39:0]), .device_select(d2_device_select), .io_select(d2_io_select),
    .io_strobe(d2_io_strobe), .exp_owner(d2_exp_owner), .slot_hit(d2_slot_hit),
    .slot_dout(d2_slot_dout), .rd_valid(d2_rd_valid)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  // One access as the address map describes it, applied to the model owner.
  task automatic model_access(input logic en, input logic [7:0] bk, input logic [15:0] a,
                              input logic w, output rec_t r);
    int  kind;
    int  n;
    logic ok;
    r = '0;
    r.valid = en;
    if (en) begin
      kind = 0;
      n = 0;
      if (bk == 8'h00 || bk == 8'h01 || bk == 8'hE0 || bk == 8'hE1) begin
        if (a >= 16'hC080 && a <= 16'hC0FF) begin
          kind = 1; n = (int'(a) - 'hC080) / 16;
        end else if (a >= 16'hC100 && a <= 16'hC7FF) begin
          kind = 2; n = (int'(a) - 'hC000) / 256;
        end else if (a >= 16'hC800 && a <= 16'hCFFF) begin
          kind = 3; n = int'(m_owner);
        end
      end
      ok = (kind != 0) && (n >= 1) && (n <= M_SLOTS) && sltromsel[n] &&
           (kind == 1 || !inhibit_cxxx);
      if (ok) begin
        if (kind == 1) r.dev = 8'(1 << n);
        if (kind == 2) r.ios = 8'(1 << n);
        if (kind == 3) r.stb = 8'(1 << n);
        if (!w && card_present[n]) begin
          r.hit  = 1'b1;
          r.dout = card_dout[8*n +: 8];
        end
      end
      if (kind == 2 && ok) m_owner = 3'(n);
      else if (kind == 3 && a == 16'hCFFF && !inhibit_cxxx) m_owner = 3'd0;
    end
  endtask

  task automatic check_outputs();
    chk("device_select", device_select, st1.dev);
    chk("io_select", io_select, st1.ios);
    chk("io_strobe", io_strobe, st1.stb);
    chk("exp_owner", {5'b0, exp_owner}, {5'b0, m_owner});
    chk("rd_valid", {7'b0, rd_valid}, {7'b0, st2.valid});
    if (st2.valid) begin
      chk("slot_hit", {7'b0, slot_hit}, {7'b0, st2.hit});
      chk("slot_dout", slot_dout, st2.dout);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_device_select"}, device_select, 8'h00);
    chk({tag, "_io_select"}, io_select, 8'h00);
    chk({tag, "_io_strobe"}, io_strobe, 8'h00);
    chk({tag, "_exp_owner"}, {5'b0, exp_owner}, 8'h00);
    chk({tag, "_slot_hit"}, {7'b0, slot_hit}, 8'h00);
    chk({tag, "_slot_dout"}, slot_dout, 8'h00);
    chk({tag, "_rd_valid"}, {7'b0, rd_valid}, 8'h00);
  endtask

  // One clock cycle: drive an access, check what the previous two produced.
  task automatic step(input logic en, input logic [7:0] bk, input logic [15:0] a,
                      input logic w);
    rec_t r;
    bus_en = en; bank = bk; addr = a; we = w;
    @(negedge clk);
    check_outputs();
    model_access(en, bk, a, w, r);
    st2 = st1;
    st1 = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 16'h0000, 1'b0);
  endtask

  initial begin
    logic [7:0]  bk;
    logic [15:0] a;
    logic [2:0]  d2_owner_before;
    logic [7:0]  banks [6];
    banks[0] = 8'h00; banks[1] = 8'h01; banks[2] = 8'hE0;
    banks[3] = 8'hE1; banks[4] = 8'h02; banks[5] = 8'hC0;

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // Device select and read return from slot 6
    sltromsel = 8'h40;
    card_present = 8'h40;
    card_dout[8*6 +: 8] = 8'hA5;
    step(1'b1, 8'h00, 16'hC0E3, 1'b0);
    idle(2);

    // Ownership of the $C800 window by slot 6, then release through $CFFF
    step(1'b1, 8'hE1, 16'hC600, 1'b0);
    idle(1);
    step(1'b1, 8'h00, 16'hC812, 1'b0);
    idle(1);
    step(1'b1, 8'h00, 16'hCFFF, 1'b0);
    idle(1);
    step(1'b1, 8'h00, 16'hC812, 1'b0);
    idle(2);

    // inhibit_cxxx blocks IOSEL/STRB but not device selects
    step(1'b1, 8'h00, 16'hC600, 1'b1);
    sltromsel = 8'h48;
    card_present = 8'h48;
    card_dout[8*3 +: 8] = 8'h3C;
    inhibit_cxxx = 1'b1;
    step(1'b1, 8'h00, 16'hC600, 1'b0);
    step(1'b1, 8'h00, 16'hC085, 1'b0);
    step(1'b1, 8'h00, 16'hC0B0, 1'b0);
    step(1'b1, 8'h00, 16'hC812, 1'b0);
    step(1'b1, 8'h00, 16'hCFFF, 1'b0);
    inhibit_cxxx = 1'b0;
    idle(2);

    // Internal slot 5, non-qualifying bank, write access
    step(1'b1, 8'h00, 16'hC500, 1'b0);
    step(1'b1, 8'h02, 16'hC600, 1'b0);
    step(1'b1, 8'h00, 16'hC0E0, 1'b1);
    idle(2);

    // Owner retained while its sltromsel bit is off; strobes resume afterwards
    sltromsel = 8'h08;
    step(1'b1, 8'h00, 16'hC812, 1'b0);
    sltromsel = 8'h48;
    step(1'b1, 8'h00, 16'hC812, 1'b0);
    idle(2);

    // Address-map edges with every slot external
    sltromsel = 8'hFF;
    card_present = 8'hFF;
    card_dout = 64'h7766554433221100;
    step(1'b1, 8'h00, 16'hC07F, 1'b0);
    step(1'b1, 8'h01, 16'hC0FF, 1'b0);
    step(1'b1, 8'hE0, 16'hC7FF, 1'b0);
    step(1'b1, 8'h00, 16'hC100, 1'b0);
    step(1'b1, 8'h00, 16'hCFFF, 1'b0);
    step(1'b1, 8'h00, 16'hD000, 1'b0);
    idle(2);

    // A four-slot build ignores slot 7
    d2_owner_before = d2_exp_owner;
    step(1'b1, 8'h00, 16'hC700, 1'b0);
    chk("n4_io_select", {3'b0, d2_io_select}, 8'h00);
    chk("n4_device_select", {3'b0, d2_device_select}, 8'h00);
    chk("n4_io_strobe", {3'b0, d2_io_strobe}, 8'h00);
    chk("n4_exp_owner", {5'b0, d2_exp_owner}, {5'b0, d2_owner_before});
    idle(1);
    chk("n4_rd_valid", {7'b0, d2_rd_valid}, 8'h01);
    chk("n4_slot_hit", {7'b0, d2_slot_hit}, 8'h00);
    chk("n4_slot_dout", d2_slot_dout, 8'h00);
    idle(1);

    // Back-to-back: owner set by one access feeds the next access's strobe
    sltromsel = 8'h40;
    card_present = 8'h40;
    step(1'b1, 8'h00, 16'hC600, 1'b0);
    step(1'b1, 8'h00, 16'hC800, 1'b0);
    step(1'b1, 8'h00, 16'hCFFF, 1'b0);
    step(1'b1, 8'h00, 16'hC600, 1'b1);
    step(1'b1, 8'h00, 16'hC900, 1'b0);
    idle(3);

    // Randomized traffic
    for (int blk = 0; blk < 6; blk++) begin
      idle(2);
      card_present = 8'($urandom);
      card_dout = {$urandom, $urandom};
      sltromsel = 8'($urandom);
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 9) == 0) sltromsel = 8'($urandom);
        inhibit_cxxx = ($urandom_range(0, 7) == 0);
        bk = banks[$urandom_range(0, 5)];
        case ($urandom_range(0, 5))
          0:       a = 16'hC080 + 16'($urandom_range(0, 127));
          1:       a = 16'hC100 + 16'($urandom_range(0, 16'h06FF));
          2:       a = 16'hC800 + 16'($urandom_range(0, 16'h07FF));
          3:       a = 16'hCFFF;
          4:       a = 16'($urandom);
          default: a = 16'hC000 | 16'($urandom_range(0, 16'h0FFF));
        endcase
        step($urandom_range(0, 9) < 7, bk, a, 1'($urandom_range(0, 1)));
      end
    end
    inhibit_cxxx = 1'b0;
    idle(2);

    // Reset in the middle of a pipelined stream abandons everything in flight
    sltromsel = 8'h40;
    card_present = 8'h40;
    step(1'b1, 8'h00, 16'hC600, 1'b0);
    step(1'b1, 8'h00, 16'hC800, 1'b0);
    reset = 1'b1;
    #1;
    check_zero("midreset");
    m_owner = 3'd0;
    st1 = '0;
    st2 = '0;
    bus_en = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
